// File: rtl/except_ctrl.sv
// except_ctrl: prioritises MEM-stage exceptions and pending interrupts into a CP0 commit code,
// then holds a fetch-redirect flush. Define EXC_INT_SYNC_EN to pass int_i through a 2-flop synchronizer.
module except_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [8:0]  mem_except_i,
    input  logic [31:0] mem_bad_vaddr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] pc_o,
    output logic [31:0] bad_vaddr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);
    localparam logic [2:0]  CNT_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [31:0] EXC_INT  = 32'h01;
    localparam logic [31:0] EXC_ADEL = 32'h04;
    localparam logic [31:0] EXC_ADES = 32'h05;
    localparam logic [31:0] EXC_SYS  = 32'h08;
    localparam logic [31:0] EXC_BP   = 32'h09;
    localparam logic [31:0] EXC_RI   = 32'h0a;
    localparam logic [31:0] EXC_OV   = 32'h0c;
    localparam logic [31:0] EXC_TR   = 32'h0d;
    localparam logic [31:0] EXC_ERET = 32'h0e;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [31:0] new_pc_nxt;
    logic [5:0]  hw;
    logic [5:0]  ip;
    logic        int_pend;
    logic        consider;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_s1, int_s2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_s1 <= '0;
            int_s2 <= '0;
        end else begin
            int_s1 <= int_i;
            int_s2 <= int_s1;
        end
    end
    assign hw = int_s2;
`else
    assign hw = int_i;
`endif

    // Timer shares hardware line 5 and is never synchronized
    assign ip       = {hw[5] | timer_int_i, hw[4:0]};
    assign int_pend = status_i[0] & ~status_i[1] &
                      ((|(ip & status_i[15:10])) | (|(cause_i[9:8] & status_i[9:8])));
    assign consider = ~rst & (state == IDLE) & mem_valid_i & ~stall_i[4];

    always_comb begin
        excepttype_o = '0;
        bad_vaddr_o  = '0;
        if (consider) begin
            if (int_pend)              excepttype_o = EXC_INT;
            else if (mem_except_i[0]) begin
                excepttype_o = EXC_ADEL;
                bad_vaddr_o  = mem_pc_i;
            end
            else if (mem_except_i[1])  excepttype_o = EXC_RI;
            else if (mem_except_i[2])  excepttype_o = EXC_SYS;
            else if (mem_except_i[3])  excepttype_o = EXC_BP;
            else if (mem_except_i[4])  excepttype_o = EXC_OV;
            else if (mem_except_i[5])  excepttype_o = EXC_TR;
            else if (mem_except_i[6]) begin
                excepttype_o = EXC_ADEL;
                bad_vaddr_o  = mem_bad_vaddr_i;
            end
            else if (mem_except_i[7]) begin
                excepttype_o = EXC_ADES;
                bad_vaddr_o  = mem_bad_vaddr_i;
            end
            else if (mem_except_i[8])  excepttype_o = EXC_ERET;
        end
    end

    assign pc_o              = rst ? '0 : mem_pc_i;
    assign is_in_delayslot_o = ~rst & mem_in_delayslot_i;
    assign flush_o           = (state == FLUSH);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        new_pc_nxt = new_pc_o;
        case (state)
            IDLE: begin
                if (excepttype_o != '0) begin
                    state_nxt  = FLUSH;
                    cnt_nxt    = CNT_LOAD;
                    new_pc_nxt = (excepttype_o == EXC_ERET) ? epc_i : EXC_VECTOR;
                end
            end
            FLUSH: begin
                if (cnt == '0) state_nxt = IDLE;
                else           cnt_nxt   = cnt - 3'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            new_pc_o <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            new_pc_o <= new_pc_nxt;
        end
    end
endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: directed vector table, hand-written multi-cycle sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_except_ctrl;
    localparam int          FC  = 2;
    localparam logic [31:0] VEC = 32'hBFC0_0380;
`ifdef EXC_INT_SYNC_EN
    localparam int INT_LAT = 2;
`else
    localparam int INT_LAT = 0;
`endif
    localparam logic [7:0] CODE_OF [9] = '{8'h04, 8'h0a, 8'h08, 8'h09, 8'h0c, 8'h0d, 8'h04, 8'h05, 8'h0e};

    logic        clk = 1'b0, rst = 1'b0;
    logic [5:0]  stall_i;
    logic        mem_valid_i, mem_in_delayslot_i, timer_int_i;
    logic [31:0] mem_pc_i, mem_bad_vaddr_i, status_i, cause_i, epc_i;
    logic [8:0]  mem_except_i;
    logic [5:0]  int_i;
    logic [31:0] excepttype_o, pc_o, bad_vaddr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o;

    int nvec = 0, nmis = 0;

    except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .mem_valid_i(mem_valid_i),
        .mem_pc_i(mem_pc_i), .mem_in_delayslot_i(mem_in_delayslot_i),
        .mem_except_i(mem_except_i), .mem_bad_vaddr_i(mem_bad_vaddr_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .int_i(int_i),
        .timer_int_i(timer_int_i), .excepttype_o(excepttype_o), .pc_o(pc_o),
        .bad_vaddr_o(bad_vaddr_o), .is_in_delayslot_o(is_in_delayslot_o),
        .flush_o(flush_o), .new_pc_o(new_pc_o)
    );

    always #5 clk = ~clk;

    // Two-edge delay of int_i, as seen by the controller when synchronized
    logic [5:0] int_d1, int_d2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            int_d1 <= '0;
            int_d2 <= '0;
        end else begin
            int_d1 <= int_i;
            int_d2 <= int_d1;
        end
    end

    typedef struct {
        string       name;
        logic [8:0]  exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] bva, status, cause, epc;
        logic        timer;
        logic [31:0] code, xbva;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input string nm, input logic [8:0] e, input logic [31:0] p, input logic d,
                       input logic [31:0] b, input logic [31:0] s, input logic [31:0] c,
                       input logic [31:0] ep, input logic t, input logic [31:0] cd, input logic [31:0] xb);
        vec_t v;
        v.name = nm; v.exc = e; v.pc = p; v.ds = d; v.bva = b; v.status = s;
        v.cause = c; v.epc = ep; v.timer = t; v.code = cd; v.xbva = xb;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in;
        stall_i = '0; mem_valid_i = 0; mem_pc_i = '0; mem_in_delayslot_i = 0;
        mem_except_i = '0; mem_bad_vaddr_i = '0; status_i = '0; cause_i = '0;
        epc_i = '0; int_i = '0; timer_int_i = 0;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (flush_o && n < 10) begin
            step;
            n++;
        end
        chk("idle_wait", 32'(flush_o), 32'h0);
    endtask

    // Reference model: 8 interrupt sources {IP7..IP2, IP1..IP0} against Status.IM
    function automatic logic m_irq(input logic [31:0] st, input logic [31:0] ca,
                                   input logic [5:0] hw, input logic tmr);
        logic [7:0] lines;
        if (!st[0] || st[1]) return 1'b0;
        lines = {hw[5] | tmr, hw[4:0], ca[9:8]};
        for (int i = 0; i < 8; i++)
            if (lines[i] && st[8+i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_pick(input logic irq, input logic [8:0] exc, input logic [31:0] pc,
                          input logic [31:0] bva, output logic [31:0] code, output logic [31:0] bv);
        code = '0;
        bv   = '0;
        if (irq) code = 32'h01;
        else begin
            for (int i = 0; i < 9; i++) begin
                if (exc[i]) begin
                    code = 32'(CODE_OF[i]);
                    bv   = (i == 0) ? pc : ((i == 6 || i == 7) ? bva : 32'h0);
                    break;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          flush_rem;
        logic [31:0] m_newpc, exp_pc, code, bv;
        logic [5:0]  hw_m;

        // Reset state with busy-looking inputs
        clr_in;
        mem_valid_i = 1; mem_pc_i = 32'h1234; mem_except_i = 9'h004; mem_in_delayslot_i = 1;
        rst = 1;
        #1;
        chk("rst_code", excepttype_o, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_bva", bad_vaddr_o, 0);
        chk("rst_ds", 32'(is_in_delayslot_o), 0);
        chk("rst_flush", 32'(flush_o), 0);
        chk("rst_newpc", new_pc_o, 0);
        step; step;
        clr_in;
        rst = 0;
        step;

        add("syscall",   9'h004, 32'hBFC00100, 0, 32'h0,        32'h0,        32'h0,   32'h0,        0, 32'h08, 32'h0);
        add("eret",      9'h100, 32'h80000010, 0, 32'h0,        32'h0,        32'h0,   32'h80001234, 0, 32'h0e, 32'h0);
        add("int_ov",    9'h010, 32'h80000020, 1, 32'h0,        32'h00000101, 32'h100, 32'h0,        0, 32'h01, 32'h0);
        add("ri_ades",   9'h082, 32'h80000030, 0, 32'h80000003, 32'h0,        32'h0,   32'h0,        0, 32'h0a, 32'h0);
        add("ades",      9'h080, 32'h80000040, 0, 32'h80000003, 32'h0,        32'h0,   32'h0,        0, 32'h05, 32'h80000003);
        add("adel_if",   9'h001, 32'hBFC00203, 1, 32'h12345678, 32'h0,        32'h0,   32'h0,        0, 32'h04, 32'hBFC00203);
        add("adel_d",    9'h040, 32'h80000050, 0, 32'h10000001, 32'h0,        32'h0,   32'h0,        0, 32'h04, 32'h10000001);
        add("timer",     9'h000, 32'h80000060, 0, 32'h0,        32'h00008001, 32'h0,   32'h0,        1, 32'h01, 32'h0);
        add("exl_mask",  9'h000, 32'h80000070, 0, 32'h0,        32'h00000103, 32'h100, 32'h0,        0, 32'h00, 32'h0);
        add("ie_off",    9'h008, 32'h80000080, 0, 32'h0,        32'h00000100, 32'h100, 32'h0,        0, 32'h09, 32'h0);
        add("trap",      9'h020, 32'h80000090, 0, 32'h0,        32'h0,        32'h0,   32'h0,        0, 32'h0d, 32'h0);
        add("brk_trap",  9'h028, 32'h800000a0, 0, 32'h0,        32'h0,        32'h0,   32'h0,        0, 32'h09, 32'h0);
        add("none",      9'h000, 32'h800000b0, 1, 32'h0,        32'h0,        32'h0,   32'h0,        0, 32'h00, 32'h0);
        add("int_adel",  9'h001, 32'h800000c1, 0, 32'h0,        32'h00000201, 32'h200, 32'h0,        0, 32'h01, 32'h0);
        add("im_off",    9'h000, 32'h800000d0, 0, 32'h0,        32'h00000001, 32'h300, 32'h0,        0, 32'h00, 32'h0);

        foreach (tbl[i]) begin
            mem_valid_i = 1; mem_except_i = tbl[i].exc; mem_pc_i = tbl[i].pc;
            mem_in_delayslot_i = tbl[i].ds; mem_bad_vaddr_i = tbl[i].bva;
            status_i = tbl[i].status; cause_i = tbl[i].cause; epc_i = tbl[i].epc;
            timer_int_i = tbl[i].timer;
            #4;
            chk({tbl[i].name, "_code"}, excepttype_o, tbl[i].code);
            chk({tbl[i].name, "_pc"}, pc_o, tbl[i].pc);
            chk({tbl[i].name, "_bva"}, bad_vaddr_o, tbl[i].xbva);
            chk({tbl[i].name, "_ds"}, 32'(is_in_delayslot_o), 32'(tbl[i].ds));
            step;
            exp_pc = (tbl[i].code == 32'h0e) ? tbl[i].epc : VEC;
            clr_in;
            if (tbl[i].code != 0) begin
                for (int k = 0; k < FC; k++) begin
                    chk({tbl[i].name, "_flush"}, 32'(flush_o), 1);
                    chk({tbl[i].name, "_newpc"}, new_pc_o, exp_pc);
                    step;
                end
            end
            chk({tbl[i].name, "_flush_end"}, 32'(flush_o), 0);
        end

        // Break presented during FLUSH is ignored
        mem_valid_i = 1; mem_except_i = 9'h004; mem_pc_i = 32'hBFC00100;
        #4 chk("fm_commit", excepttype_o, 32'h08);
        step;
        mem_except_i = 9'h008;
        for (int k = 0; k < FC; k++) begin
            #4;
            chk("fm_masked", excepttype_o, 0);
            chk("fm_flush", 32'(flush_o), 1);
            step;
        end
        clr_in;
        #1 chk("fm_end", 32'(flush_o), 0);
        step;

        // Break under MEM stall commits on the first unstalled cycle
        mem_valid_i = 1; mem_except_i = 9'h008; mem_pc_i = 32'h80000200; stall_i = 6'h10;
        for (int k = 0; k < 2; k++) begin
            #4;
            chk("stall_code", excepttype_o, 0);
            chk("stall_flush", 32'(flush_o), 0);
            step;
        end
        stall_i = 6'h0;
        #4 chk("unstall_code", excepttype_o, 32'h09);
        step;
        chk("unstall_flush", 32'(flush_o), 1);
        clr_in;
        wait_idle;

        // Reset in first FLUSH cycle, then a clean syscall after release
        mem_valid_i = 1; mem_except_i = 9'h004; mem_pc_i = 32'hBFC00100;
        #4 chk("rmf_commit", excepttype_o, 32'h08);
        step;
        chk("rmf_flush", 32'(flush_o), 1);
        #1 rst = 1;
        #1;
        chk("rmf_flush_rst", 32'(flush_o), 0);
        chk("rmf_newpc_rst", new_pc_o, 0);
        chk("rmf_code_rst", excepttype_o, 0);
        step; step;
        rst = 0;
        #4;
        chk("rmf_re_code", excepttype_o, 32'h08);
        chk("rmf_re_pc", pc_o, 32'hBFC00100);
        chk("rmf_re_ds", 32'(is_in_delayslot_o), 0);
        step;
        clr_in;
        for (int k = 0; k < FC; k++) begin
            chk("rmf_re_flush", 32'(flush_o), 1);
            chk("rmf_re_newpc", new_pc_o, VEC);
            step;
        end
        chk("rmf_re_end", 32'(flush_o), 0);

        // Hardware interrupt line 0, latency depends on the synchronizer
        mem_valid_i = 1; mem_pc_i = 32'h80000300; status_i = 32'h00000401;
        #4 chk("hwint_pre", excepttype_o, 0);
        step;
        int_i = 6'h01;
        for (int k = 0; k <= INT_LAT; k++) begin
            #4 chk("hwint_code", excepttype_o, (k == INT_LAT) ? 32'h01 : 32'h0);
            step;
        end
        clr_in;
        wait_idle;
        step; step; step;
        mem_valid_i = 1; mem_pc_i = 32'h80000310; status_i = 32'h00000403;
        step;
        int_i = 6'h01;
        for (int k = 0; k < 4; k++) begin
            #4 chk("hwint_exl", excepttype_o, 0);
            step;
        end
        clr_in;
        step; step; step;

        // Randomized traffic against the reference model
        rst = 1;
        step;
        rst = 0;
        flush_rem = 0;
        m_newpc = '0;
        for (int n = 0; n < 400; n++) begin
            mem_valid_i = ($urandom_range(0, 9) < 8);
            mem_pc_i = $urandom; mem_bad_vaddr_i = $urandom; epc_i = $urandom;
            mem_in_delayslot_i = 1'($urandom);
            mem_except_i = ($urandom_range(0, 2) == 0) ?
                           (9'(1 << $urandom_range(0, 8)) | (($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'h0)) : 9'h0;
            status_i = 32'($urandom) & 32'h0000_FF03;
            cause_i = 32'($urandom) & 32'h0000_0300;
            int_i = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
            timer_int_i = ($urandom_range(0, 7) == 0);
            stall_i = (6'($urandom) & 6'h2F) | (($urandom_range(0, 4) == 0) ? 6'h10 : 6'h0);
            #4;
`ifdef EXC_INT_SYNC_EN
            hw_m = int_d2;
`else
            hw_m = int_i;
`endif
            if (flush_rem == 0 && mem_valid_i && !stall_i[4])
                m_pick(m_irq(status_i, cause_i, hw_m, timer_int_i), mem_except_i, mem_pc_i, mem_bad_vaddr_i, code, bv);
            else begin
                code = '0;
                bv = '0;
            end
            chk("rnd_code", excepttype_o, code);
            chk("rnd_bva", bad_vaddr_o, bv);
            chk("rnd_pc", pc_o, mem_pc_i);
            chk("rnd_ds", 32'(is_in_delayslot_o), 32'(mem_in_delayslot_i));
            chk("rnd_flush", 32'(flush_o), 32'(flush_rem > 0));
            chk("rnd_newpc", new_pc_o, m_newpc);
            @(posedge clk);
            if (flush_rem > 0) flush_rem--;
            else if (code != 0) begin
                flush_rem = FC;
                m_newpc = (code == 32'h0e) ? epc_i : VEC;
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/except_ctrl.md
# except_ctrl

Exception/interrupt controller that drives the CP0 register block's exception-commit inputs. It sits at the MEM stage and prioritises the instruction's exception flags and pending interrupts against the current CP0 Status/Cause/EPC. It presents one excepttype code per committed exception and then runs a flush sequence that redirects fetch to the exception vector, or to EPC for ERET.

## Interface
- `EXC_VECTOR`, default 32'hBFC0_0380: target PC for every exception other than ERET.
- `FLUSH_CYCLES`, default 2, range 1..7: number of cycles `flush_o` is held after a commit.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall_i` in 6: pipeline stall bus; bit 4 = MEM stage stalled.
- `mem_valid_i` in 1: MEM stage holds a real instruction.
- `mem_pc_i` in 32: PC of the MEM instruction.
- `mem_in_delayslot_i` in 1: MEM instruction is in a delay slot.
- `mem_except_i` in 9: exception flags.
  - bit 0: adel_if
  - bit 1: ri
  - bit 2: syscall
  - bit 3: break
  - bit 4: ov
  - bit 5: trap
  - bit 6: adel (data)
  - bit 7: ades
  - bit 8: eret
- `mem_bad_vaddr_i` in 32: data address of the MEM load/store.
- `status_i`, `cause_i`, `epc_i` in 32 each: current CP0 values.
- `int_i` in 6: hardware interrupt lines.
- `timer_int_i` in 1: timer interrupt; ORed into line 5.
- `excepttype_o` out 32: commit code to CP0; 0 = none.
- `pc_o` out 32: faulting PC to CP0.
- `bad_vaddr_o` out 32: bad address to CP0.
- `is_in_delayslot_o` out 1: delay-slot flag to CP0.
- `flush_o` out 1: kill IF..MEM.
- `new_pc_o` out 32: redirect target, valid while `flush_o`=1.

## Operation
- Codes:
  - interrupt 0x01
  - adel 0x04 (fetch or data)
  - ades 0x05
  - syscall 0x08
  - break 0x09
  - ri 0x0a
  - ov 0x0c
  - trap 0x0d
  - eret 0x0e
- Interrupt pending when all of the following hold:
  - `status_i[0]`=1 (IE)
  - `status_i[1]`=0 (EXL)
  - `|({hw[5]|timer_int_i, hw[4:0]} & status_i[15:10]) | |(cause_i[9:8] & status_i[9:8])`
- `hw` = the `int_i` lines as configured (see Configuration).
- Priority, highest first: interrupt, adel_if, ri, syscall, break, ov, trap, adel, ades, eret.
- Candidates are considered only when all of the following hold: state=IDLE, `mem_valid_i`=1, `stall_i[4]`=0. Otherwise `excepttype_o`=0.
- `pc_o` = `mem_pc_i`.
- `is_in_delayslot_o` = `mem_in_delayslot_i`.
- `bad_vaddr_o` selection:
  - adel_if: `mem_pc_i`
  - adel/ades data: `mem_bad_vaddr_i`
  - otherwise 0
- FSM, IDLE:
  - A nonzero code in cycle C moves the FSM to FLUSH at C+1.
  - At the same edge: counter loads `FLUSH_CYCLES`-1; `new_pc_o` loads `epc_i` for eret, else `EXC_VECTOR`.
- FSM, FLUSH:
  - `flush_o`=1 and `excepttype_o`=0; MEM inputs are ignored.
  - Counter decrements each cycle; at 0 the FSM returns to IDLE on the next edge.
- `new_pc_o` holds its value until the next commit.

## Timing
- Reset (async, immediate), all outputs zero:
  - state=IDLE, counter=0
  - `flush_o`=0, `new_pc_o`=0
  - synchronizer flops=0
  - `excepttype_o`, `pc_o`, `bad_vaddr_o`, `is_in_delayslot_o` all 0
- `excepttype_o`/`pc_o`/`bad_vaddr_o`/`is_in_delayslot_o` are combinational. They are sampled by CP0 at the end of cycle C.
- `flush_o` is registered: high for exactly `FLUSH_CYCLES` cycles, C+1..C+`FLUSH_CYCLES`.
- The FLUSH window covers CP0's one-cycle Status.EXL update. An interrupt can therefore never re-fire on the instruction after a commit.
- Back-to-back: a new commit is possible at cycle C+`FLUSH_CYCLES`+1 at the earliest.
- Reset asserted mid-FLUSH: `flush_o` drops immediately; IDLE on release.
- Stall in the commit cycle: no commit. The same instruction is re-evaluated when the stall clears.

## Configuration
- `EXC_INT_SYNC_EN` defined: `hw` = `int_i` through a 2-flop synchronizer. An interrupt is visible 2 cycles after `int_i` rises.
- Not defined: `hw` = `int_i` directly, with zero latency and no synchronizer flops.

## Test plan
- **Syscall:** syscall at `mem_pc_i`=0xBFC00100, not in a delay slot, `status_i`=0.
  - Same cycle: `excepttype_o`=0x08, `pc_o`=0xBFC00100, `is_in_delayslot_o`=0.
  - Next 2 cycles: `flush_o`=1, `new_pc_o`=0xBFC00380.
- **ERET:** eret with `epc_i`=0x80001234 gives `excepttype_o`=0x0e, then `new_pc_o`=0x80001234 with a 2-cycle flush.
- **Interrupt (macro defined):** `status_i`=0x00000401, `int_i[0]` rises with a valid instruction in MEM.
  - `excepttype_o`=0x01 on the 2nd cycle after the rise.
  - Repeat with `status_i`=0x00000403 (EXL set): no commit.
- **Priority:** interrupt+ov together gives 0x01; ri+ades gives 0x0a; ades alone with `mem_bad_vaddr_i`=0x80000003 gives 0x05 with `bad_vaddr_o`=0x80000003.
- **Flush/stall masking:**
  - Break presented during FLUSH: ignored.
  - Break with `stall_i[4]`=1: `excepttype_o`=0; it commits in the first unstalled cycle.
- **Reset mid-FLUSH:** `rst` asserted in the first FLUSH cycle makes `flush_o`, `new_pc_o` and `excepttype_o` 0 immediately. The first commit after release behaves as in the syscall scenario.
